av_config_i2c_responder: RTL and testbench

I2C target (responder) for the audio/video configuration bus. The system's av_config controller is the I2C initiator on SDAT/SCLK; this block sits at the far end of that bus and models a WM8731-style write-only codec configuration port in fabric. It is used as a bench/loopback target and as a soft codec-register mirror. It oversamples SCL/SDA on a single system clock, decodes START/STOP and 7-bit addressed write frames, drives ACK through an open-drain enable, and emits one register-write strobe per valid 2-byte frame.

---
 rtl/av_config_i2c_responder.sv | 207 ++++++++++++++++++++
 tb/tb_av_config_i2c_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/av_config_i2c_responder.sv
// Write-only I2C target modelling a WM8731-style codec configuration port.
// Oversamples SCL/SDA, decodes addressed 2-byte writes and ACKs through an open-drain enable.

module av_config_i2c_glitch_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    localparam logic [3:0] FILT_MAX = 4'(FILTER_LEN - 1);

    logic [1:0] sync_q;
    logic [3:0] cnt_q;
    logic       level_q;
    logic       prev_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], pin_i};
            prev_q <= level_q;
            if (sync_q[1] != level_q) begin
                if (cnt_q == FILT_MAX) begin
                    level_q <= sync_q[1];
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = level_q & ~prev_q;
    assign fall_o  = ~level_q & prev_q;
endmodule

module av_config_i2c_responder #(
    parameter logic [6:0] DEVICE_ADDR = 7'h1A,
    parameter int         FILTER_LEN  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       reg_wr_valid,
    output logic [6:0] reg_wr_addr,
    output logic [8:0] reg_wr_data,
    output logic       busy,
    output logic       frame_error
);
    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_BYTE1, ST_ACK1,
        ST_BYTE2, ST_ACK2, ST_EXTRA, ST_IGNORE
    } state_t;

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    av_config_i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk(clk), .reset(reset), .pin_i(scl_in),
        .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    av_config_i2c_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk(clk), .reset(reset), .pin_i(sda_in),
        .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] byte1_q, byte1_d;
    logic       sda_oe_q, sda_oe_d;
    logic       valid_q, valid_d;
    logic [6:0] addr_q, addr_d;
    logic [8:0] data_q, data_d;
    logic       busy_q, busy_d;
    logic       err_q, err_d;

    logic       start_det, stop_det;
    logic [7:0] shift_next;

    assign start_det  = sda_fall & scl_lvl;
    assign stop_det   = sda_rise & scl_lvl;
    assign shift_next = {shift_q[6:0], sda_lvl};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            byte1_q   <= '0;
            sda_oe_q  <= 1'b0;
            valid_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            byte1_q   <= byte1_d;
            sda_oe_q  <= sda_oe_d;
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        byte1_d   = byte1_q;
        sda_oe_d  = sda_oe_q;
        valid_d   = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        busy_d    = busy_q;
        err_d     = 1'b0;

        // Bus conditions override everything, including a pending ACK release.
        if (start_det || stop_det) begin
            if (((state_q == ST_ADDR || state_q == ST_BYTE1 || state_q == ST_BYTE2) && bit_cnt_q != 4'd0) ||
                (busy_q && (state_q == ST_ACK1 || state_q == ST_BYTE2))) begin
                err_d = 1'b1;
            end
            busy_d    = 1'b0;
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = start_det ? ST_ADDR : ST_IDLE;
        end else begin
            case (state_q)
                ST_ADDR, ST_BYTE1, ST_BYTE2, ST_EXTRA: begin
                    if (scl_rise) begin
                        shift_d   = shift_next;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            case (state_q)
                                ST_ADDR: begin
                                    if (shift_next == {DEVICE_ADDR, 1'b0}) begin
                                        state_d = ST_ADDR_ACK;
                                        busy_d  = 1'b1;
                                    end else begin
                                        state_d = ST_IGNORE;
                                    end
                                end
                                ST_BYTE1: begin
                                    byte1_d = shift_next;
                                    state_d = ST_ACK1;
                                end
                                ST_BYTE2: begin
                                    valid_d = 1'b1;
                                    addr_d  = byte1_q[7:1];
                                    data_d  = {byte1_q[0], shift_next};
                                    state_d = ST_ACK2;
                                end
                                default: state_d = ST_IGNORE;
                            endcase
                        end
                    end
                end
                ST_ADDR_ACK, ST_ACK1, ST_ACK2: begin
                    // First falling edge drives the ACK, the second releases it.
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            case (state_q)
                                ST_ADDR_ACK: state_d = ST_BYTE1;
                                ST_ACK1:     state_d = ST_BYTE2;
                                default:     state_d = ST_EXTRA;
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_oe       = sda_oe_q;
    assign reg_wr_valid = valid_q;
    assign reg_wr_addr  = addr_q;
    assign reg_wr_data  = data_q;
    assign busy         = busy_q;
    assign frame_error  = err_q;
endmodule

// File: tb/tb_av_config_i2c_responder.sv
// Directed bench for av_config_i2c_responder: an I2C initiator model drives the bus,
// monitors log strobes/errors/ACKs and a frame table plus corner sequences check them.

module tb_av_config_i2c_responder;
    localparam int Q = 10;  // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_in = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_in;
    logic       sda_oe;
    logic       reg_wr_valid;
    logic [6:0] reg_wr_addr;
    logic [8:0] reg_wr_data;
    logic       busy;
    logic       frame_error;

    assign sda_in = sda_m & ~sda_oe;

    av_config_i2c_responder #(.DEVICE_ADDR(7'h1A), .FILTER_LEN(3)) dut (
        .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in),
        .sda_oe(sda_oe), .reg_wr_valid(reg_wr_valid), .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data), .busy(busy), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          strobe_cnt = 0;
    int          err_cnt = 0;
    int          oe_rises = 0;
    int          busy_cycles = 0;
    logic        oe_prev = 1'b0;
    logic [15:0] strobe_log [64];

    always @(negedge clk) begin
        if (!reset) begin
            if (reg_wr_valid) begin
                if (strobe_cnt < 64) strobe_log[strobe_cnt] = {reg_wr_addr, reg_wr_data};
                strobe_cnt++;
            end
            if (frame_error) err_cnt++;
            if (busy) busy_cycles++;
            if (sda_oe && !oe_prev) oe_rises++;
        end
        oe_prev = sda_oe;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;  wait_clks(Q);
        scl_in = 1'b1; wait_clks(Q);
        sda_m = 1'b0;  wait_clks(Q);
        scl_in = 1'b0; wait_clks(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;  wait_clks(Q);
        scl_in = 1'b1; wait_clks(Q);
        sda_m = 1'b1;  wait_clks(2 * Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input bit glitch);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i];  wait_clks(Q);
            scl_in = 1'b1;
            if (glitch && i == 4) begin
                wait_clks(Q);
                scl_in = 1'b0; wait_clks(2);
                scl_in = 1'b1; wait_clks(Q - 2);
            end else begin
                wait_clks(2 * Q);
            end
            scl_in = 1'b0; wait_clks(Q);
        end
    endtask

    task automatic ack_clock(output logic ack);
        sda_m = 1'b1;  wait_clks(Q);
        scl_in = 1'b1; wait_clks(Q);
        ack = sda_oe;  wait_clks(Q);
        scl_in = 1'b0; wait_clks(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit glitch, output logic ack);
        send_bits(b, glitch);
        ack_clock(ack);
    endtask

    typedef struct {
        int          n;
        logic [31:0] bytes;
        logic [3:0]  ack;
        int          strobes;
        logic [6:0]  addr;
        logic [8:0]  data;
        int          errs;
        logic        busy_seen;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs [NV];

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int   s0, e0, o0, b0;
        logic ack;
        logic got_oe;

        vecs[0] = '{3, 32'h34129F00, 4'b0111, 1, 7'h09, 9'h09F, 0, 1'b1};
        vecs[1] = '{3, 32'h36AA5500, 4'b0000, 0, 7'h00, 9'h000, 0, 1'b0};
        vecs[2] = '{1, 32'h35000000, 4'b0000, 0, 7'h00, 9'h000, 0, 1'b0};
        vecs[3] = '{2, 32'h341F0000, 4'b0011, 0, 7'h00, 9'h000, 1, 1'b1};
        vecs[4] = '{4, 32'h340A0B55, 4'b0111, 1, 7'h05, 9'h00B, 0, 1'b1};
        vecs[5] = '{3, 32'h34FE8000, 4'b0111, 1, 7'h7F, 9'h080, 0, 1'b1};

        wait_clks(5);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_valid", reg_wr_valid, 0);
        check("rst_addr", reg_wr_addr, 0);
        check("rst_data", reg_wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ferr", frame_error, 0);
        reset = 1'b0;
        wait_clks(10);

        for (int v = 0; v < NV; v++) begin
            s0 = strobe_cnt; e0 = err_cnt; o0 = oe_rises; b0 = busy_cycles;
            i2c_start();
            for (int i = 0; i < vecs[v].n; i++) begin
                send_byte(vecs[v].bytes[31 - 8 * i -: 8], 1'b0, ack);
                check($sformatf("v%0d_ack%0d", v, i), ack, vecs[v].ack[i]);
            end
            i2c_stop();
            wait_clks(10);
            check($sformatf("v%0d_strobes", v), strobe_cnt - s0, vecs[v].strobes);
            if (vecs[v].strobes > 0 && strobe_cnt > s0) begin
                check($sformatf("v%0d_addr", v), strobe_log[strobe_cnt - 1][15:9], vecs[v].addr);
                check($sformatf("v%0d_data", v), strobe_log[strobe_cnt - 1][8:0], vecs[v].data);
            end
            check($sformatf("v%0d_ferr", v), err_cnt - e0, vecs[v].errs);
            check($sformatf("v%0d_oe_pulses", v), oe_rises - o0, $countones(vecs[v].ack));
            check($sformatf("v%0d_busy_seen", v), busy_cycles != b0, vecs[v].busy_seen);
            check($sformatf("v%0d_busy_end", v), busy, 0);
            check($sformatf("v%0d_oe_end", v), sda_oe, 0);
        end

        // Two frames joined by a repeated START; fourth byte of the second frame is NACKed.
        s0 = strobe_cnt; e0 = err_cnt;
        i2c_start();
        send_byte(8'h34, 1'b0, ack); check("rs_a_ack0", ack, 1);
        send_byte(8'h0C, 1'b0, ack); check("rs_a_ack1", ack, 1);
        send_byte(8'h07, 1'b0, ack); check("rs_a_ack2", ack, 1);
        i2c_start();
        check("rs_busy_after_sr", busy, 0);
        send_byte(8'h34, 1'b0, ack); check("rs_b_ack0", ack, 1);
        send_byte(8'h0E, 1'b0, ack); check("rs_b_ack1", ack, 1);
        send_byte(8'h42, 1'b0, ack); check("rs_b_ack2", ack, 1);
        send_byte(8'h55, 1'b0, ack); check("rs_b_nack3", ack, 0);
        i2c_stop();
        wait_clks(10);
        check("rs_strobes", strobe_cnt - s0, 2);
        if (strobe_cnt - s0 == 2) begin
            check("rs_strobe0", strobe_log[s0], {7'h06, 9'h007});
            check("rs_strobe1", strobe_log[s0 + 1], {7'h07, 9'h042});
        end
        check("rs_ferr", err_cnt - e0, 0);
        check("rs_busy_end", busy, 0);

        // Reset while ACK2 is being driven low.
        e0 = err_cnt;
        i2c_start();
        send_byte(8'h34, 1'b0, ack);
        send_byte(8'h01, 1'b0, ack);
        send_bits(8'h02, 1'b0);
        got_oe = 1'b0;
        for (int i = 0; i < 20 && !got_oe; i++) begin
            if (sda_oe) got_oe = 1'b1;
            else wait_clks(1);
        end
        check("rst_ack2_oe_seen", got_oe, 1);
        check("rst_ack2_prior_strobe", strobe_log[strobe_cnt - 1], {7'h00, 9'h102});
        s0 = strobe_cnt;
        reset = 1'b1;
        wait_clks(1);
        check("rst_ack2_oe_cleared", sda_oe, 0);
        check("rst_ack2_addr_cleared", reg_wr_addr, 0);
        reset = 1'b0;
        ack_clock(ack);
        i2c_stop();
        wait_clks(10);
        check("rst_ack2_no_strobe", strobe_cnt - s0, 0);
        check("rst_ack2_busy", busy, 0);

        // Short glitches on an idle bus, then a frame with an SCL glitch inside a data bit.
        o0 = oe_rises; b0 = busy_cycles;
        scl_in = 1'b0; wait_clks(2); scl_in = 1'b1; wait_clks(20);
        sda_m = 1'b0;  wait_clks(2); sda_m = 1'b1;  wait_clks(20);
        check("glitch_idle_busy", busy_cycles - b0, 0);
        check("glitch_idle_oe", oe_rises - o0, 0);
        s0 = strobe_cnt;
        i2c_start();
        send_byte(8'h34, 1'b0, ack); check("post_rst_ack0", ack, 1);
        send_byte(8'h01, 1'b0, ack); check("post_rst_ack1", ack, 1);
        send_byte(8'hFF, 1'b1, ack); check("post_rst_ack2", ack, 1);
        i2c_stop();
        wait_clks(10);
        check("post_rst_strobes", strobe_cnt - s0, 1);
        check("post_rst_strobe", strobe_log[strobe_cnt - 1], {7'h00, 9'h1FF});
        check("post_rst_ferr", err_cnt - e0, 0);
        check("post_rst_busy_end", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
